// File: rtl/dcache_addr_sequencer.sv
// dcache_addr_sequencer: turns address-queue entries into cache requests, expanding sweep commands into 128 line operations
module dcache_addr_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        q_empty,
  input  logic [32:0] q_dout,
  output logic        q_rd_en,
  output logic        q_dec_line,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_op,
  input  logic        mem_ready,
  output logic        busy,
  output logic        sweep_done
);
  typedef enum logic [1:0] {IDLE, ACCESS, SWEEP} state_t;
  state_t state, state_nxt, cur;
  logic [6:0] line_cnt, cnt_nxt;
  logic done_nxt, accept;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      line_cnt   <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_cnt   <= cnt_nxt;
      sweep_done <= done_nxt;
    end
  // reset masks the registered state so nothing is requested or popped during reset
  assign cur  = rst ? IDLE : state;
  assign busy = cur != IDLE;
  always_comb begin
    state_nxt  = cur;
    cnt_nxt    = line_cnt;
    done_nxt   = 1'b0;
    mem_valid  = (cur != IDLE) && !q_empty;
    mem_op     = (cur == SWEEP) ? (q_dout[0] ? 2'b10 : 2'b01) : 2'b00;
    mem_addr   = (cur == SWEEP) ? {q_dout[31:3], 3'b000} : q_dout[31:0];
    accept     = mem_valid && mem_ready;
    q_rd_en    = accept && (cur == ACCESS || line_cnt == 7'd127);
    q_dec_line = accept && cur == SWEEP && line_cnt != 7'd127;
    case (cur)
      IDLE: begin
        state_nxt = q_empty ? IDLE : (q_dout[32] ? SWEEP : ACCESS);
        cnt_nxt   = '0;
      end
      ACCESS: state_nxt = (q_empty || accept) ? IDLE : ACCESS;
      SWEEP:
        if (q_empty || q_rd_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = q_rd_en;
        end else if (q_dec_line) cnt_nxt = line_cnt + 7'd1;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_addr_sequencer.sv
// tb_dcache_addr_sequencer: queue model + scoreboard bench for dcache_addr_sequencer
module tb_dcache_addr_sequencer;
  logic clk, rst, q_empty, q_rd_en, q_dec_line, mem_valid, mem_ready, busy, sweep_done;
  logic [32:0] q_dout;
  logic [31:0] mem_addr;
  logic [1:0] mem_op;

  dcache_addr_sequencer dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_dout(q_dout), .q_rd_en(q_rd_en),
    .q_dec_line(q_dec_line), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_op(mem_op),
    .mem_ready(mem_ready), .busy(busy), .sweep_done(sweep_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic        pop;
  } exp_t;

  logic [32:0] mq[$];
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int rd_tot = 0, dec_tot = 0, done_tot = 0;
  logic s_rd = 0, s_dec = 0, done_exp = 0;
  logic rdy_hold = 1, rdy_rand = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_q();
    q_empty = mq.size() == 0;
    q_dout  = q_empty ? 33'd0 : mq[0];
  endtask

  // expected request stream derived directly from the entry: one access, or 128 line ops
  task automatic push(input logic [32:0] e);
    exp_t x;
    mq.push_back(e);
    if (!e[32]) begin
      x.addr = e[31:0];
      x.op   = 2'b00;
      x.pop  = 1'b1;
      exp_q.push_back(x);
    end else
      for (int k = 0; k < 128; k++) begin
        x.addr = {e[31:10], 10'd0} + 32'(((int'(e[9:3]) + k) % 128) * 8);
        x.op   = e[0] ? 2'b10 : 2'b01;
        x.pop  = (k == 127);
        exp_q.push_back(x);
      end
    drive_q();
  endtask

  // queue model: pops on q_rd_en, steps the line index on q_dec_line
  initial begin : queue_model
    logic [32:0] h;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && mq.size() > 0) begin
        if (s_rd) void'(mq.pop_front());
        else if (s_dec) begin
          h = mq[0];
          h[9:3] = h[9:3] + 7'd1;
          mq[0] = h;
        end
      end
      mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
      drive_q();
    end
  end

  initial begin : monitor
    exp_t e;
    logic acc, prev_stall;
    logic [31:0] prev_addr;
    logic [1:0] prev_op;
    prev_stall = 0;
    prev_addr = 0;
    prev_op = 0;
    forever begin
      @(negedge clk);
      acc = mem_valid && mem_ready;
      s_rd = q_rd_en;
      s_dec = q_dec_line;
      rd_tot += int'(q_rd_en);
      dec_tot += int'(q_dec_line);
      done_tot += int'(sweep_done);
      chk("sweep_done", sweep_done, done_exp);
      done_exp = 0;
      chk("valid_when_empty", mem_valid && q_empty, 0);
      chk("rd_and_dec", q_rd_en && q_dec_line, 0);
      if (mem_valid) chk("busy_when_valid", busy, 1);
      if (prev_stall && !rst) begin
        chk("stall_valid", mem_valid, 1);
        chk("stall_addr", mem_addr, prev_addr);
        chk("stall_op", mem_op, prev_op);
      end
      if (acc) begin
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("req_addr", mem_addr, e.addr);
          chk("req_op", mem_op, e.op);
          chk("req_rd_en", q_rd_en, e.pop);
          chk("req_dec_line", q_dec_line, !e.pop);
          done_exp = e.pop && e.op != 2'b00;
        end
      end else begin
        chk("rd_idle", q_rd_en, 0);
        chk("dec_idle", q_dec_line, 0);
      end
      prev_stall = mem_valid && !mem_ready && !rst;
      prev_addr = mem_addr;
      prev_op = mem_op;
    end
  end

  task automatic drain(input int budget, output int t);
    t = 0;
    while ((exp_q.size() != 0 || mq.size() != 0 || busy) && t < budget) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("drain_timeout", t >= budget, 0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_valid"}, mem_valid, 0);
    chk({name, "_rd"}, q_rd_en, 0);
    chk({name, "_dec"}, q_dec_line, 0);
    chk({name, "_done"}, sweep_done, 0);
  endtask

  initial begin : stimulus
    int t, rd0, dec0, done0;
    logic [32:0] e;
    rst = 1;
    mem_ready = 1;
    drive_q();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk_quiet("post_reset");

    // single access with latency check
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    push(33'h0_1234_5678);
    @(negedge clk);
    chk("lat_first_cycle", mem_valid, 0);
    @(negedge clk);
    chk("lat_valid_next", mem_valid, 1);
    drain(50, t);
    chk("access_rd_cnt", rd_tot - rd0, 1);

    // backpressure: five stalled cycles then accept
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    rdy_hold = 0;
    push(33'h0_CAFE_0010);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_valid && t < 20);
    chk("bp_valid_seen", mem_valid, 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_valid", mem_valid, 1);
    end
    rdy_hold = 1;
    drain(50, t);
    chk("bp_rd_cnt", rd_tot - rd0, 1);

    // flush sweep at full rate
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    dec0 = dec_tot;
    done0 = done_tot;
    push(33'h1_ABCD_E001);
    drain(400, t);
    chk("flush_full_rate", t <= 131, 1);
    chk("flush_dec_cnt", dec_tot - dec0, 127);
    chk("flush_rd_cnt", rd_tot - rd0, 1);
    @(negedge clk);
    chk("flush_done_cnt", done_tot - done0, 1);

    // invalidate sweep, nonzero start line, random ready
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    dec0 = dec_tot;
    rdy_rand = 1;
    push(33'h1_5555_5A38);
    drain(2000, t);
    chk("inv_dec_cnt", dec_tot - dec0, 127);
    chk("inv_rd_cnt", rd_tot - rd0, 1);

    // reset mid-sweep at line 40
    rdy_rand = 0;
    rdy_hold = 1;
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    dec0 = dec_tot;
    push(33'h1_0000_0101);
    t = 0;
    while (dec_tot - dec0 < 40 && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("mid_sweep_reached", dec_tot - dec0, 40);
    rst = 1;
    mq.delete();
    exp_q.delete();
    drive_q();
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk_quiet("mid_reset");
    chk("mid_reset_no_rd", rd_tot - rd0, 0);
    @(posedge clk);
    #2;
    push(33'h0_DEAD_BEEF);
    drain(50, t);
    chk("after_reset_rd", rd_tot - rd0, 1);

    // mixed stream: access, sweep, access
    rdy_rand = 1;
    @(posedge clk);
    #2;
    rd0 = rd_tot;
    push(33'h0_0000_1000);
    push({1'b1, $urandom()});
    push(33'h0_0000_2000);
    drain(2000, t);
    chk("mixed_rd_cnt", rd_tot - rd0, 3);

    // random stream with random gaps
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      e = {($urandom_range(0, 9) < 3), $urandom()};
      push(e);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    drain(5000, t);
    @(negedge clk);
    chk_quiet("end_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_addr_sequencer.md
DCACHE_ADDR_SEQUENCER -- requirements
Module: dcache_addr_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning; reset is rst, synchronous, active-high; clock is clk.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 q_empty  in  1  address queue holds no valid entry at its registered output.
REQ-005 q_dout  in  33  queue head entry; bit 32 = 1 sweep command, 0 single access.
REQ-006 q_rd_en  out  1  pop the queue head; takes effect at the next edge.
REQ-007 q_dec_line  out  1  step q_dout[9:3] by one at the next edge.
REQ-008 mem_valid  out  1  request to the cache port is valid.
REQ-009 mem_addr  out  32  request address.
REQ-010 mem_op  out  2  00 access, 01 invalidate line, 10 flush line (writeback and invalidate), 11 unused.
REQ-011 mem_ready  in  1  cache accepts the request in this cycle.
REQ-012 busy  out  1  state is not IDLE.
REQ-013 sweep_done  out  1  one-cycle registered pulse after a sweep completes.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and SWEEP.
REQ-015 In IDLE with q_empty=0, the FSM SHALL go to SWEEP if q_dout[32]=1, otherwise to ACCESS; with q_empty=1 it SHALL stay in IDLE.
REQ-016 In IDLE, mem_valid, q_rd_en and q_dec_line SHALL all be 0.
REQ-017 In ACCESS: mem_valid=~q_empty, mem_op=00, mem_addr=q_dout[31:0].
REQ-018 In ACCESS, a cycle with mem_valid=1 and mem_ready=1 SHALL assert q_rd_en combinationally and go to IDLE.
REQ-019 In SWEEP: mem_valid=~q_empty, mem_op=10 if q_dout[0]=1 else 01, mem_addr={q_dout[31:10], q_dout[9:3], 3'b000}.
REQ-020 The block SHALL hold a 7-bit line counter line_cnt, which is 0 on entry to SWEEP.
REQ-021 In SWEEP, an accepted request with line_cnt<127 SHALL assert q_dec_line and increment line_cnt.
REQ-022 In SWEEP, an accepted request with line_cnt=127 SHALL assert q_rd_en (not q_dec_line), clear line_cnt, go to IDLE, and set sweep_done=1 for the next cycle only.
REQ-023 Each sweep entry SHALL therefore issue exactly 128 line operations: 127 q_dec_line pulses and 1 q_rd_en.
REQ-024 The line index wraps modulo 128 inside the queue; the block SHALL NOT correct for a nonzero starting q_dout[9:3].
REQ-025 q_rd_en and q_dec_line SHALL never both be 1 in the same cycle.
REQ-026 Neither q_rd_en nor q_dec_line SHALL be 1 while q_empty=1.
REQ-027 While mem_valid=1 and mem_ready=0, mem_addr and mem_op SHALL stay stable and mem_valid SHALL stay 1 until accepted.
REQ-028 If q_empty=1 while in ACCESS or SWEEP, the FSM SHALL return to IDLE, clear line_cnt, and issue no request.
REQ-029 Latency: an entry first visible at cycle N gives mem_valid=1 at N+1.
REQ-030 After a pop at cycle M, the next entry gives mem_valid at M+2 at the earliest; the access rate is therefore at most one per 2 cycles.
REQ-031 In SWEEP, back-to-back line operations SHALL run one per cycle while mem_ready=1, because q_dout[9:3] updates at the edge after q_dec_line.
REQ-032 busy SHALL be 1 whenever the state is ACCESS or SWEEP.

Reset
REQ-033 When rst=1 at an edge, the block SHALL force state IDLE, line_cnt=0 and sweep_done=0.
REQ-034 During and immediately after reset, mem_valid, q_rd_en, q_dec_line and busy SHALL be 0; mem_addr and mem_op are don't-care while mem_valid=0.
REQ-035 rst SHALL take priority over every other event, including an accept in the same cycle.
REQ-036 A reset in mid-sweep SHALL abandon the sweep with no q_rd_en issued; the queue is reset by the same rst.

Verification
REQ-037 Single access: q_dout=33'h0_1234_5678, mem_ready held 1 -> one request with mem_op=00 and mem_addr=32'h1234_5678, q_rd_en one cycle, then IDLE.
REQ-038 Backpressure: mem_ready=0 for 5 cycles, then 1 -> mem_valid and mem_addr stable for 6 cycles, exactly one q_rd_en.
REQ-039 Flush sweep: q_dout=33'h1_ABCD_E001 with a queue model that steps bits 9:3 on q_dec_line -> 128 ops with mem_op=10, addresses 32'hABCD_E000 + 8*k for k=0..127 (bits 9:3 wrapping mod 128), 127 q_dec_line pulses, 1 q_rd_en, then sweep_done.
REQ-040 Invalidate sweep with random mem_ready -> mem_op=01, exactly 128 accepts, q_rd_en and q_dec_line never asserted together.
REQ-041 Reset at line_cnt=40 -> next cycle IDLE with all outputs 0; a following access entry is serviced normally.
REQ-042 Mixed stream (access, sweep, access) -> all entries serviced in order, busy=0 only in IDLE gaps.
